frame_scheduler: RTL and testbench
==================================

Name: frame_scheduler

Overview:
- Double-buffer controller between the video timing generator and the renderer (320x180 internal resolution, displayed at 4x).
- Each frame it decides which buffer is scanned out and which is drawn, and pulses the renderer to start.
- Swaps buffers only at a frame boundary, and only once the renderer has finished.
- Latches the gyro pose (pitch/roll/yaw) at render start, counts dropped frames, and recovers from a renderer that never completes.

Parameters:
- TIMEOUT_FRAMES, 8: number of new_frame pulses spent in RENDER without done before the pass is aborted; legal range 1..255.
- CNT_W, 16: width of the dropped-frame counter and the cycle counter.

Ports:
- clk_in  input  1  pixel clock (74.25 MHz).
- rst_in  input  1  synchronous active-high reset.
- new_frame_in  input  1  one-cycle pulse at start of frame, from the video signal generator.
- render_done_in  input  1  one-cycle pulse from the renderer: draw buffer complete.
- freeze_in  input  1  level; when high, no new render is started.
- pitch_in, roll_in, yaw_in  input  9 each  processed gyro angles.
- render_start_out  output  1  one-cycle pulse that starts a render pass.
- render_abort_out  output  1  one-cycle pulse on timeout.
- pitch_out, roll_out, yaw_out  output  9 each  pose latched at render start.
- display_buf_out  output  1  buffer index being scanned out.
- draw_buf_out  output  1  buffer index being rendered; always equal to ~display_buf_out.
- swap_out  output  1  one-cycle pulse when the buffers swap.
- dropped_count_out  output  CNT_W  saturating count of frames repeated because a render was late.
- state_out  output  2  current state: IDLE=0, RENDER=1, WAIT_SWAP=2.
- render_cycles_out  output  CNT_W  see Optional Feature.

Behaviour:
- All outputs are registered. Each output changes on the clk_in edge that samples its triggering input (1-cycle latency).
- Reset values:
  - state IDLE; display_buf_out 0; draw_buf_out 1.
  - All pulse outputs 0; pose outputs 0; dropped_count_out 0; render_cycles_out 0.
  - Internal timeout counter 0.
- IDLE:
  - new_frame_in with freeze_in=0: latch pitch/roll/yaw, pulse render_start_out, go to RENDER.
  - Otherwise stay in IDLE.
- RENDER:
  - render_done_in and no new_frame_in: go to WAIT_SWAP.
  - render_done_in and new_frame_in in the same cycle: handled exactly as new_frame_in arriving in WAIT_SWAP. The swap happens this cycle and no frame is dropped.
  - new_frame_in without done:
    - increment dropped_count_out, saturating at all-ones;
    - increment the timeout counter;
    - if the counter reaches TIMEOUT_FRAMES: pulse render_abort_out, clear the counter, go to IDLE, do not swap.
  - The timeout counter clears on every entry to RENDER.
- WAIT_SWAP, on new_frame_in:
  - toggle display_buf_out and draw_buf_out, and pulse swap_out;
  - if freeze_in=0: latch pose, pulse render_start_out in the same cycle as swap_out, go to RENDER;
  - if freeze_in=1: go to IDLE.
- render_done_in in IDLE or WAIT_SWAP is ignored, with no state change.
- freeze_in asserted mid-RENDER does not abort the pass. It only takes effect at the next start decision.
- Pose outputs hold their value between starts. A change on the gyro inputs is never visible mid-render.
- Reset asserted in any state returns every output to its reset value on that edge, including during a pulse.

Optional Feature:
- Macro: FRAME_SCHEDULER_STATS_EN.
- Defined:
  - An internal CNT_W counter clears on render_start_out and increments every cycle in RENDER, saturating.
  - On render_done_in its value is copied to render_cycles_out, which holds until the next done.
  - An aborted pass does not update render_cycles_out.
- Not defined: render_cycles_out is tied to 0 and no counter logic is synthesized.

Test Plan:
- Nominal:
  - Stimulus: reset, new_frame at t=0, done 1000 cycles later, next new_frame.
  - Required: render_start_out 1 cycle after the first new_frame; state goes 0→1→2.
  - Required: at the second new_frame, swap_out and render_start_out pulse together; display_buf_out=1, draw_buf_out=0; dropped_count_out=0.
- Late render:
  - Stimulus: start, then 3 new_frames without done, then done, then new_frame.
  - Required: dropped_count_out=3, one swap, display_buf_out toggles once.
- Timeout with TIMEOUT_FRAMES=8:
  - Stimulus: start, then 8 new_frames without done.
  - Required: render_abort_out pulses on the 8th; state=IDLE; dropped_count_out=8; buffers not swapped.
  - Required: the next new_frame restarts rendering.
- Same-cycle events:
  - Stimulus: render_done_in and new_frame_in asserted in the same cycle while in RENDER.
  - Required: swap_out=1 and render_start_out=1; dropped_count_out unchanged.
- Freeze plus pose latch:
  - Stimulus: pitch_in=9'd100 at start, pitch_in changed to 200 mid-render.
  - Required: pitch_out stays 100.
  - Stimulus: freeze_in=1, then done, then new_frame.
  - Required: swap occurs, no start, state=IDLE.
  - Stimulus: with freeze still 1, further new_frames.
  - Required: no starts.
- Reset mid-RENDER and stats:
  - Stimulus: rst_in during RENDER.
  - Required: all outputs at reset values the next cycle.
  - With FRAME_SCHEDULER_STATS_EN defined: start-to-done of 500 cycles gives render_cycles_out=500 (±1 per the defined counting).

Source files
------------

// File: rtl/frame_scheduler.sv
// Double-buffer scheduler: picks scan-out/draw buffers per frame, starts the renderer,
// latches gyro pose, counts dropped frames and aborts stuck passes. Optional stats: FRAME_SCHEDULER_STATS_EN.
module frame_scheduler #(
    parameter int unsigned TIMEOUT_FRAMES = 8,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             new_frame_in,
    input  logic             render_done_in,
    input  logic             freeze_in,
    input  logic [8:0]       pitch_in,
    input  logic [8:0]       roll_in,
    input  logic [8:0]       yaw_in,
    output logic             render_start_out,
    output logic             render_abort_out,
    output logic [8:0]       pitch_out,
    output logic [8:0]       roll_out,
    output logic [8:0]       yaw_out,
    output logic             display_buf_out,
    output logic             draw_buf_out,
    output logic             swap_out,
    output logic [CNT_W-1:0] dropped_count_out,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] render_cycles_out
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RENDER    = 2'd1;
    localparam logic [1:0] ST_WAIT_SWAP = 2'd2;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_FRAMES);

    logic [1:0]       state_q, state_d;
    logic             start_q, start_d;
    logic             abort_q, abort_d;
    logic             swap_q, swap_d;
    logic             display_q, display_d;
    logic             draw_q, draw_d;
    logic [8:0]       pitch_q, pitch_d;
    logic [8:0]       roll_q, roll_d;
    logic [8:0]       yaw_q, yaw_d;
    logic [CNT_W-1:0] dropped_q, dropped_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [7:0]       tmo_inc;
    logic             begin_pass;
    logic             do_swap;

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        abort_d    = 1'b0;
        swap_d     = 1'b0;
        display_d  = display_q;
        draw_d     = draw_q;
        pitch_d    = pitch_q;
        roll_d     = roll_q;
        yaw_d      = yaw_q;
        dropped_d  = dropped_q;
        tmo_d      = tmo_q;
        tmo_inc    = tmo_q + 8'd1;
        begin_pass = 1'b0;
        do_swap    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (new_frame_in && !freeze_in) begin
                    begin_pass = 1'b1;
                end
            end
            ST_RENDER: begin
                if (render_done_in) begin
                    // Done coinciding with the frame boundary swaps immediately, no drop.
                    if (new_frame_in) begin
                        do_swap = 1'b1;
                    end else begin
                        state_d = ST_WAIT_SWAP;
                    end
                end else if (new_frame_in) begin
                    if (dropped_q != '1) begin
                        dropped_d = dropped_q + CNT_W'(1);
                    end
                    if (tmo_inc == TMO_LIMIT) begin
                        abort_d = 1'b1;
                        tmo_d   = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
            end
            ST_WAIT_SWAP: begin
                if (new_frame_in) begin
                    do_swap = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_swap) begin
            display_d = ~display_q;
            draw_d    = ~draw_q;
            swap_d    = 1'b1;
            if (freeze_in) begin
                state_d = ST_IDLE;
            end else begin
                begin_pass = 1'b1;
            end
        end

        if (begin_pass) begin
            start_d = 1'b1;
            pitch_d = pitch_in;
            roll_d  = roll_in;
            yaw_d   = yaw_in;
            tmo_d   = 8'd0;
            state_d = ST_RENDER;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            swap_q    <= 1'b0;
            display_q <= 1'b0;
            draw_q    <= 1'b1;
            pitch_q   <= 9'd0;
            roll_q    <= 9'd0;
            yaw_q     <= 9'd0;
            dropped_q <= '0;
            tmo_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
            swap_q    <= swap_d;
            display_q <= display_d;
            draw_q    <= draw_d;
            pitch_q   <= pitch_d;
            roll_q    <= roll_d;
            yaw_q     <= yaw_d;
            dropped_q <= dropped_d;
            tmo_q     <= tmo_d;
        end
    end

`ifdef FRAME_SCHEDULER_STATS_EN
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] cyc_inc;
    logic [CNT_W-1:0] rcyc_q, rcyc_d;

    // Copy the incremented value so a done N cycles after start reports N.
    always_comb begin
        cyc_inc = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
        cyc_d   = cyc_q;
        rcyc_d  = rcyc_q;
        if (state_q == ST_RENDER) begin
            cyc_d = cyc_inc;
            if (render_done_in) begin
                rcyc_d = cyc_inc;
            end
        end
        if (start_d) begin
            cyc_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cyc_q  <= '0;
            rcyc_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            rcyc_q <= rcyc_d;
        end
    end

    assign render_cycles_out = rcyc_q;
`else
    assign render_cycles_out = '0;
`endif

    assign state_out         = state_q;
    assign render_start_out  = start_q;
    assign render_abort_out  = abort_q;
    assign swap_out          = swap_q;
    assign display_buf_out   = display_q;
    assign draw_buf_out      = draw_q;
    assign pitch_out         = pitch_q;
    assign roll_out          = roll_q;
    assign yaw_out           = yaw_q;
    assign dropped_count_out = dropped_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: behavioural model feeds a scoreboard queue, plus fixed-value checks.
module tb_frame_scheduler;

    localparam int TMO   = 8;
    localparam int CNT_W = 16;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic             new_frame_in = 1'b0;
    logic             render_done_in = 1'b0;
    logic             freeze_in = 1'b0;
    logic [8:0]       pitch_in = 9'd0;
    logic [8:0]       roll_in = 9'd0;
    logic [8:0]       yaw_in = 9'd0;
    logic             render_start_out;
    logic             render_abort_out;
    logic [8:0]       pitch_out;
    logic [8:0]       roll_out;
    logic [8:0]       yaw_out;
    logic             display_buf_out;
    logic             draw_buf_out;
    logic             swap_out;
    logic [CNT_W-1:0] dropped_count_out;
    logic [1:0]       state_out;
    logic [CNT_W-1:0] render_cycles_out;

    frame_scheduler #(.TIMEOUT_FRAMES(TMO), .CNT_W(CNT_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .new_frame_in(new_frame_in),
        .render_done_in(render_done_in), .freeze_in(freeze_in),
        .pitch_in(pitch_in), .roll_in(roll_in), .yaw_in(yaw_in),
        .render_start_out(render_start_out), .render_abort_out(render_abort_out),
        .pitch_out(pitch_out), .roll_out(roll_out), .yaw_out(yaw_out),
        .display_buf_out(display_buf_out), .draw_buf_out(draw_buf_out),
        .swap_out(swap_out), .dropped_count_out(dropped_count_out),
        .state_out(state_out), .render_cycles_out(render_cycles_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic             start;
        logic             abort;
        logic             swap;
        logic             disp;
        logic             draw;
        logic [1:0]       state;
        logic [CNT_W-1:0] dropped;
        logic [8:0]       pitch;
        logic [8:0]       roll;
        logic [8:0]       yaw;
        logic [CNT_W-1:0] rcyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    int               m_state = 0;
    logic             m_disp = 1'b0;
    logic [CNT_W-1:0] m_drop = '0;
    int               m_tmo = 0;
    logic [8:0]       m_pitch = 9'd0, m_roll = 9'd0, m_yaw = 9'd0;
    int               m_cyc = 0;
    int               m_rcyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic nf, input logic done, input logic rst);
        exp_t e;
        logic bp;
        logic sw;
        logic was_render;
        int   cyc_next;
        e  = '0;
        bp = 1'b0;
        sw = 1'b0;
        if (rst) begin
            m_state = 0; m_disp = 1'b0; m_drop = '0; m_tmo = 0;
            m_pitch = 9'd0; m_roll = 9'd0; m_yaw = 9'd0; m_cyc = 0; m_rcyc = 0;
        end else begin
            was_render = (m_state == 1);
            cyc_next   = (m_cyc == 65535) ? m_cyc : m_cyc + 1;
            case (m_state)
                0: if (nf && !freeze_in) bp = 1'b1;
                1: begin
                    if (done && nf) sw = 1'b1;
                    else if (done) m_state = 2;
                    else if (nf) begin
                        if (m_drop != '1) m_drop = m_drop + 1'b1;
                        m_tmo++;
                        if (m_tmo == TMO) begin
                            e.abort = 1'b1; m_tmo = 0; m_state = 0;
                        end
                    end
                end
                2: if (nf) sw = 1'b1;
                default: m_state = 0;
            endcase
            if (sw) begin
                m_disp = ~m_disp;
                e.swap = 1'b1;
                if (freeze_in) m_state = 0;
                else bp = 1'b1;
            end
            if (bp) begin
                e.start = 1'b1;
                m_pitch = pitch_in; m_roll = roll_in; m_yaw = yaw_in;
                m_tmo = 0; m_state = 1;
            end
            if (was_render) begin
                m_cyc = cyc_next;
                if (done) m_rcyc = cyc_next;
            end
            if (bp) m_cyc = 0;
        end
        e.state   = 2'(m_state);
        e.disp    = m_disp;
        e.draw    = ~m_disp;
        e.dropped = m_drop;
        e.pitch   = m_pitch;
        e.roll    = m_roll;
        e.yaw     = m_yaw;
`ifdef FRAME_SCHEDULER_STATS_EN
        e.rcyc    = CNT_W'(m_rcyc);
`else
        e.rcyc    = '0;
`endif
        sb_q.push_back(e);
    endtask

    task automatic step(input logic nf, input logic done, input logic rst);
        exp_t e;
        @(negedge clk_in);
        new_frame_in   = nf;
        render_done_in = done;
        rst_in         = rst;
        model(nf, done, rst);
        @(posedge clk_in);
        #1;
        new_frame_in   = 1'b0;
        render_done_in = 1'b0;
        rst_in         = 1'b0;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("start",   32'(render_start_out),  32'(e.start));
            check("abort",   32'(render_abort_out),  32'(e.abort));
            check("swap",    32'(swap_out),          32'(e.swap));
            check("display", 32'(display_buf_out),   32'(e.disp));
            check("draw",    32'(draw_buf_out),      32'(e.draw));
            check("state",   32'(state_out),         32'(e.state));
            check("dropped", 32'(dropped_count_out), 32'(e.dropped));
            check("pitch",   32'(pitch_out),         32'(e.pitch));
            check("roll",    32'(roll_out),          32'(e.roll));
            check("yaw",     32'(yaw_out),           32'(e.yaw));
            check("rcyc",    32'(render_cycles_out), 32'(e.rcyc));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_disp",  32'(display_buf_out), 32'd0);
        check("rst_draw",  32'(draw_buf_out), 32'd1);
        idle(2);

        // Nominal pass
        pitch_in = 9'd17; roll_in = 9'd33; yaw_in = 9'd301;
        step(1'b1, 1'b0, 1'b0);
        check("nom_start", 32'(render_start_out), 32'd1);
        check("nom_state1", 32'(state_out), 32'd1);
        check("nom_pitch", 32'(pitch_out), 32'd17);
        idle(999);
        step(1'b0, 1'b1, 1'b0);
        check("nom_state2", 32'(state_out), 32'd2);
        idle(5);
        step(1'b1, 1'b0, 1'b0);
        check("nom_swap", 32'(swap_out), 32'd1);
        check("nom_start2", 32'(render_start_out), 32'd1);
        check("nom_disp", 32'(display_buf_out), 32'd1);
        check("nom_draw", 32'(draw_buf_out), 32'd0);
        check("nom_drop", 32'(dropped_count_out), 32'd0);

        // Late render: three frames repeated
        for (int i = 0; i < 3; i++) begin
            idle(4);
            step(1'b1, 1'b0, 1'b0);
            check("late_noswap", 32'(swap_out), 32'd0);
        end
        check("late_drop", 32'(dropped_count_out), 32'd3);
        idle(2);
        step(1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b0);
        check("late_swap", 32'(swap_out), 32'd1);
        check("late_disp", 32'(display_buf_out), 32'd0);
        check("late_drop2", 32'(dropped_count_out), 32'd3);

        // Timeout after TMO frames without done
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("tmo_disp_pre", 32'(display_buf_out), 32'd1);
        for (int i = 0; i < TMO; i++) begin
            idle(3);
            step(1'b1, 1'b0, 1'b0);
        end
        check("tmo_abort", 32'(render_abort_out), 32'd1);
        check("tmo_state", 32'(state_out), 32'd0);
        check("tmo_drop", 32'(dropped_count_out), 32'd8);
        check("tmo_disp", 32'(display_buf_out), 32'd1);
        idle(2);
        step(1'b1, 1'b0, 1'b0);
        check("tmo_restart", 32'(render_start_out), 32'd1);
        check("tmo_rstate", 32'(state_out), 32'd1);

        // Same-cycle done and new_frame
        idle(3);
        step(1'b1, 1'b1, 1'b0);
        check("same_swap", 32'(swap_out), 32'd1);
        check("same_start", 32'(render_start_out), 32'd1);
        check("same_drop", 32'(dropped_count_out), 32'd8);
        check("same_disp", 32'(display_buf_out), 32'd0);

        // Pose latch and freeze
        idle(2);
        step(1'b0, 1'b1, 1'b0);
        pitch_in = 9'd100;
        step(1'b1, 1'b0, 1'b0);
        check("pose_latch", 32'(pitch_out), 32'd100);
        idle(2);
        pitch_in = 9'd200;
        idle(10);
        check("pose_hold", 32'(pitch_out), 32'd100);
        freeze_in = 1'b1;
        idle(2);
        check("frz_midrender", 32'(state_out), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("frz_swap", 32'(swap_out), 32'd1);
        check("frz_nostart", 32'(render_start_out), 32'd0);
        check("frz_idle", 32'(state_out), 32'd0);
        for (int i = 0; i < 2; i++) begin
            idle(3);
            step(1'b1, 1'b0, 1'b0);
            check("frz_hold", 32'(render_start_out), 32'd0);
        end
        freeze_in = 1'b0;

        // Reset mid-render, and reset on the edge that would pulse start
        step(1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b1);
        check("rstm_state", 32'(state_out), 32'd0);
        check("rstm_pitch", 32'(pitch_out), 32'd0);
        check("rstm_draw", 32'(draw_buf_out), 32'd1);
        step(1'b1, 1'b0, 1'b1);
        check("rstp_start", 32'(render_start_out), 32'd0);

        // Render cycle statistics
        idle(2);
        step(1'b1, 1'b0, 1'b0);
        idle(499);
        step(1'b0, 1'b1, 1'b0);
`ifdef FRAME_SCHEDULER_STATS_EN
        check("stats_500", 32'(render_cycles_out), 32'd500);
`else
        check("stats_off", 32'(render_cycles_out), 32'd0);
`endif
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
